// File: rtl/vga_pkg.sv
// Shared definitions for the frame writer and the display pixel generator:
// pixel colour codes, pixels-per-word packing and the writer state encoding.
package vga_pkg;

  localparam int PIX_DW = 2;

  localparam logic [1:0] PIX_GREY  = 2'b00;
  localparam logic [1:0] PIX_RED   = 2'b01;
  localparam logic [1:0] PIX_GREEN = 2'b10;
  localparam logic [1:0] PIX_WHITE = 2'b11;

  localparam int PIX_PER_WORD = 16 / PIX_DW;

  // Number of whole pixels of width dw that fit in one 16-bit memory word.
  function automatic int pix_per_word(input int dw);
    return 16 / dw;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } fw_state_t;

endpackage

// File: rtl/frame_addr_gen.sv
// Frame write address and word counter. Advances once per memory write,
// steps over the flag word, and wraps to the base address after the last
// word of a frame (flagging that write with a one-cycle frame_done).
module frame_addr_gen #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          FRAME_WORDS = 38400,
  parameter logic [15:0] FLAG_ADDR   = 16'h4B00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_restart,
  input  logic        i_adv,
  output logic [15:0] o_addr,
  output logic        o_frame_done
);

  localparam logic [15:0] LAST_COUNT = 16'(FRAME_WORDS - 1);

  logic [15:0] r_addr;
  logic [15:0] r_count;
  logic [15:0] w_addr_inc;
  logic        w_last;

  assign w_addr_inc = r_addr + 16'd1;
  assign w_last     = (r_count == LAST_COUNT);

  // Address/count update: restart on start-of-frame, otherwise step per write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
    end else if (i_restart) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
    end else if (i_adv) begin
      if (w_last) begin
        r_addr  <= BASE_ADDR;
        r_count <= '0;
      end else begin
        r_count <= r_count + 16'd1;
        // The flag word is owned by the reader; never land on it.
        r_addr  <= (w_addr_inc == FLAG_ADDR) ? (FLAG_ADDR + 16'd1) : w_addr_inc;
      end
    end
  end

  assign o_addr       = r_addr;
  assign o_frame_done = i_adv & w_last;

endmodule

// File: rtl/frame_writer.sv
// Packs a pixel stream into 16-bit words and writes them to frame memory,
// yielding the memory port whenever the display reader holds it (bright=1).
//
// Pixel handshake: a pixel transfers on a rising clk edge where
// pix_valid && pix_ready are both high; pix_ready does not depend on
// pix_valid. sof is only meaningful on a transferring pixel.
module frame_writer
  import vga_pkg::*;
#(
  parameter int          DATA_WIDTH  = 2,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          FRAME_WORDS = 38400,
  parameter logic [15:0] FLAG_ADDR   = 16'h4B00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sof,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix,
  output logic                  pix_ready,
  input  logic                  bright,
  output logic                  mem_we,
  output logic [15:0]           mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  frame_done,
  output logic [1:0]            o_dbg_state
);

  localparam int         PPW       = pix_per_word(DATA_WIDTH);
  localparam logic [4:0] LAST_SLOT = 5'(PPW - 1);

  fw_state_t   r_state;
  fw_state_t   w_state_next;
  logic        r_en;
  logic [4:0]  r_slot;
  logic [4:0]  w_slot_cur;
  logic [15:0] r_pack;
  logic [15:0] w_pack_next;
  logic        w_accept;
  logic        w_start;
  logic        w_take;
  logic        w_full;

  assign w_accept   = pix_valid & pix_ready;
  assign w_start    = w_accept & sof;
  // Outside FILL only a start-of-frame pixel is kept.
  assign w_take     = w_accept & (sof | (r_state == ST_FILL));
  assign w_slot_cur = w_start ? 5'd0 : r_slot;
  assign w_full     = w_take & (w_slot_cur == LAST_SLOT);

  // State register; r_en holds pix_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_en    <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_next = w_full ? ST_WRITE : ST_FILL;
      ST_FILL:  if (w_full) w_state_next = ST_WRITE;
      ST_WRITE: if (mem_we) w_state_next = ST_FILL;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; the write strobe always yields to bright.
  always_comb begin
    pix_ready = 1'b0;
    mem_we    = 1'b0;
    case (r_state)
      ST_IDLE, ST_FILL: pix_ready = r_en;
      ST_WRITE:         mem_we    = ~bright;
      default:          pix_ready = 1'b0;
    endcase
  end

  assign o_dbg_state = r_state;

  // Next pack word: sof clears the word so upper unused bits stay zero.
  always_comb begin
    w_pack_next = r_pack;
    if (w_start) begin
      w_pack_next = '0;
      w_pack_next[DATA_WIDTH-1:0] = pix;
    end else if (w_take) begin
      for (int k = 0; k < PPW; k++) begin
        if (r_slot == 5'(k)) w_pack_next[k*DATA_WIDTH +: DATA_WIDTH] = pix;
      end
    end
  end

  // Pack word and slot index; the word is frozen while in WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot <= '0;
      r_pack <= '0;
    end else begin
      r_pack <= w_pack_next;
      if (w_take) r_slot <= w_full ? 5'd0 : (w_slot_cur + 5'd1);
    end
  end

  assign mem_wdata = r_pack;

  frame_addr_gen #(
    .BASE_ADDR  (BASE_ADDR),
    .FRAME_WORDS(FRAME_WORDS),
    .FLAG_ADDR  (FLAG_ADDR)
  ) u_addr_gen (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_restart   (w_start),
    .i_adv       (mem_we),
    .o_addr      (mem_addr),
    .o_frame_done(frame_done)
  );

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer. Two instances share one input stream: dut_a uses
// default parameters, dut_b a short frame placed just below the flag word so
// the flag skip and frame wrap are reached within a few hundred cycles.
module tb_frame_writer;
  import vga_pkg::*;

  localparam int          FW_A   = 38400;
  localparam logic [15:0] BASE_A = 16'h0000;
  localparam logic [15:0] FLAG_A = 16'h4B00;
  localparam int          FW_B   = 48;
  localparam logic [15:0] BASE_B = 16'h4AE0;
  localparam logic [15:0] FLAG_B = 16'h4B00;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sof = 1'b0;
  logic        pix_valid = 1'b0;
  logic        bright = 1'b0;
  logic [1:0]  pix = 2'b00;

  logic        pix_ready_a, mem_we_a, frame_done_a;
  logic [15:0] mem_addr_a, mem_wdata_a;
  logic [1:0]  dbg_a;
  logic        pix_ready_b, mem_we_b, frame_done_b;
  logic [15:0] mem_addr_b, mem_wdata_b;
  logic [1:0]  dbg_b;

  always #5 clk = ~clk;

  frame_writer dut_a (
    .clk(clk), .reset(reset), .sof(sof), .pix_valid(pix_valid), .pix(pix),
    .pix_ready(pix_ready_a), .bright(bright), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .frame_done(frame_done_a),
    .o_dbg_state(dbg_a)
  );

  frame_writer #(
    .DATA_WIDTH(2), .BASE_ADDR(BASE_B), .FRAME_WORDS(FW_B), .FLAG_ADDR(FLAG_B)
  ) dut_b (
    .clk(clk), .reset(reset), .sof(sof), .pix_valid(pix_valid), .pix(pix),
    .pix_ready(pix_ready_b), .bright(bright), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .frame_done(frame_done_b),
    .o_dbg_state(dbg_b)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          m_pix[$];
  bit          m_idle = 1'b1;
  int          m_word_n = 0;
  bit          defer_write = 1'b0;
  int          g_hold = -1;
  logic [15:0] last_wdata_a = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Address of the n-th word since start-of-frame: linear from base,
  // one extra step once the flag word has been passed, modulo the frame.
  function automatic logic [15:0] exp_addr(input int base, input int flag, input int fw, input int n);
    int idx;
    int a;
    idx = n % fw;
    a   = base + idx;
    if (base < flag && a >= flag) a = a + 1;
    return 16'(a);
  endfunction

  function automatic logic exp_fd(input int fw, input int n);
    return ((n % fw) == (fw - 1));
  endfunction

  function automatic logic [15:0] pack_word();
    int w;
    w = 0;
    for (int i = 0; i < 8; i++) w = w | (m_pix[i] << (2 * i));
    return 16'(w);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_write();
    logic [15:0] w;
    int          hold;
    w    = exp_q.pop_front();
    hold = (g_hold < 0) ? int'($urandom_range(0, 2)) : g_hold;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      bright    = 1'b1;
      pix_valid = 1'($urandom_range(0, 1));
      sof       = 1'($urandom_range(0, 1));
      pix       = 2'($urandom_range(0, 3));
      #1;
      chk("hold_we_a", mem_we_a, 1'b0);
      chk("hold_we_b", mem_we_b, 1'b0);
      chk("hold_ready_a", pix_ready_a, 1'b0);
      chk("hold_state_a", dbg_a, ST_WRITE);
      chk("hold_wdata_a", mem_wdata_a, w);
      chk("hold_addr_a", mem_addr_a, exp_addr(BASE_A, FLAG_A, FW_A, m_word_n));
    end
    @(negedge clk);
    bright    = 1'b0;
    pix_valid = 1'($urandom_range(0, 1));
    sof       = 1'($urandom_range(0, 1));
    pix       = 2'($urandom_range(0, 3));
    #1;
    chk("wr_we_a", mem_we_a, 1'b1);
    chk("wr_we_b", mem_we_b, 1'b1);
    chk("wr_ready_a", pix_ready_a, 1'b0);
    chk("wr_wdata_a", mem_wdata_a, w);
    chk("wr_wdata_b", mem_wdata_b, w);
    chk("wr_addr_a", mem_addr_a, exp_addr(BASE_A, FLAG_A, FW_A, m_word_n));
    chk("wr_addr_b", mem_addr_b, exp_addr(BASE_B, FLAG_B, FW_B, m_word_n));
    chk("wr_fd_a", frame_done_a, exp_fd(FW_A, m_word_n));
    chk("wr_fd_b", frame_done_b, exp_fd(FW_B, m_word_n));
    last_wdata_a = mem_wdata_a;
    m_word_n++;
  endtask

  task automatic pixel(input bit s, input logic [1:0] p);
    @(negedge clk);
    sof       = s;
    pix_valid = 1'b1;
    pix       = p;
    bright    = 1'($urandom_range(0, 1));
    #1;
    chk("px_ready_a", pix_ready_a, 1'b1);
    chk("px_ready_b", pix_ready_b, 1'b1);
    chk("px_we_a", mem_we_a, 1'b0);
    if (s) begin
      m_idle = 1'b0;
      m_pix.delete();
      m_word_n = 0;
    end
    if (!m_idle) begin
      m_pix.push_back(int'(p));
      if (m_pix.size() == 8) begin
        exp_q.push_back(pack_word());
        m_pix.delete();
        if (!defer_write) do_write();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      pix_valid = 1'b0;
      sof       = 1'($urandom_range(0, 1));
      pix       = 2'($urandom_range(0, 3));
      bright    = 1'($urandom_range(0, 1));
      #1;
      chk("idle_ready_a", pix_ready_a, 1'b1);
      chk("idle_we_a", mem_we_a, 1'b0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b0;
    pix_valid = 1'b0;
    bright    = 1'($urandom_range(0, 1));
    #1;
    chk("rst_ready_a", pix_ready_a, 1'b0);
    chk("rst_ready_b", pix_ready_b, 1'b0);
    chk("rst_we_a", mem_we_a, 1'b0);
    chk("rst_we_b", mem_we_b, 1'b0);
    chk("rst_addr_a", mem_addr_a, BASE_A);
    chk("rst_addr_b", mem_addr_b, BASE_B);
    chk("rst_wdata_a", mem_wdata_a, 16'h0000);
    chk("rst_fd_b", frame_done_b, 1'b0);
    chk("rst_state_a", dbg_a, ST_IDLE);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_ready_a", pix_ready_a, 1'b0);
    m_idle = 1'b1;
    m_pix.delete();
    exp_q.delete();
    m_word_n = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    apply_reset();

    // Pixels without sof in IDLE are dropped.
    repeat (3) pixel(1'b0, 2'($urandom_range(0, 3)));
    idle(2);

    // Known pattern, immediate write.
    g_hold = 0;
    pixel(1'b1, PIX_GREY);  pixel(1'b0, PIX_RED);
    pixel(1'b0, PIX_GREEN); pixel(1'b0, PIX_WHITE);
    pixel(1'b0, PIX_GREY);  pixel(1'b0, PIX_RED);
    pixel(1'b0, PIX_GREEN); pixel(1'b0, PIX_WHITE);
    chk("e4e4_word", last_wdata_a, 16'hE4E4);

    // Reader holds the port for 5 cycles.
    g_hold = 5;
    repeat (8) pixel(1'b0, 2'($urandom_range(0, 3)));
    g_hold = -1;

    // sof after a 3-pixel partial word restarts the frame.
    repeat (3) pixel(1'b0, 2'($urandom_range(0, 3)));
    pixel(1'b1, 2'($urandom_range(0, 3)));
    repeat (7) pixel(1'b0, 2'($urandom_range(0, 3)));

    // Reset while a write is pending.
    defer_write = 1'b1;
    pixel(1'b1, 2'($urandom_range(0, 3)));
    repeat (7) pixel(1'b0, 2'($urandom_range(0, 3)));
    defer_write = 1'b0;
    @(negedge clk);
    bright    = 1'b1;
    pix_valid = 1'b0;
    #1;
    chk("pend_we_a", mem_we_a, 1'b0);
    chk("pend_state_a", dbg_a, ST_WRITE);
    chk("pend_ready_a", pix_ready_a, 1'b0);
    apply_reset();
    repeat (8) pixel(1'b0, 2'($urandom_range(0, 3)));
    pixel(1'b1, 2'($urandom_range(0, 3)));
    repeat (7) pixel(1'b0, 2'($urandom_range(0, 3)));

    // Long random stream: crosses the flag word and wraps dut_b's frame.
    for (int w = 0; w < 52; w++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        pixel((w == 0) && (i == 0), 2'($urandom_range(0, 3)));
      end
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
